// File: rtl/controller_fsm_cwt.sv
// Central sequencer of the CWT datapath: captures one FFT frame. For each of
// 15 scales it then walks the band-limited bins through the multiplier and
// wavelet ROM, feeds the IFFT in quarters and stores the IFFT result into that
// scale's output RAM bank.
module controller_fsm_cwt (
    input  logic         clk,
    input  logic         rst,
    input  logic         fft_ready_inputs,
    input  logic         fft_correct,
    input  logic         ifft_correct,
    output logic [127:0] reg_en_fft,
    output logic [6:0]   sel_mux_128x1,
    output logic [7:0]   wavlet_rom_addr,
    output logic [127:0] reg_en_ifft,
    output logic [1:0]   ifft_sel_mux_4x1,
    output logic         ifft_ready_inputs,
    output logic         ifft_scale_ram_write_enable_1,
    output logic         ifft_scale_ram_write_enable_2,
    output logic         ifft_scale_ram_write_enable_3,
    output logic         ifft_scale_ram_write_enable_4,
    output logic         ifft_scale_ram_write_enable_5,
    output logic         ifft_scale_ram_write_enable_6,
    output logic         ifft_scale_ram_write_enable_7,
    output logic         ifft_scale_ram_write_enable_8,
    output logic         ifft_scale_ram_write_enable_9,
    output logic         ifft_scale_ram_write_enable_10,
    output logic         ifft_scale_ram_write_enable_11,
    output logic         ifft_scale_ram_write_enable_12,
    output logic         ifft_scale_ram_write_enable_13,
    output logic         ifft_scale_ram_write_enable_14,
    output logic         ifft_scale_ram_write_enable_15,
    output logic [1:0]   ifft_scale_output_ram_addr
);

    localparam logic [4:0] S_IDLE        = 5'd0;
    localparam logic [4:0] S_FFT_LOAD    = 5'd1;
    localparam logic [4:0] S_FFT_WAIT    = 5'd2;
    localparam logic [4:0] S_FFT_CAPTURE = 5'd3;
    localparam logic [4:0] S_SCALE_FIRST = 5'd5;
    localparam logic [4:0] S_SCALE_LAST  = 5'd19;

    localparam logic [1:0] P_MULT  = 2'd0;
    localparam logic [1:0] P_LOAD  = 2'd1;
    localparam logic [1:0] P_WAIT  = 2'd2;
    localparam logic [1:0] P_WRITE = 2'd3;

    logic [4:0] current_state, state_next;
    logic [1:0] phase, phase_next;
    logic [3:0] state_counter, counter_next;
    logic       pending, pending_next;

    logic       in_scale;
    logic [4:0] scale_offset;
    logic [3:0] scale_idx;
    logic [3:0] band_last;
    logic [6:0] band_base;
    logic [7:0] rom_base;
    logic [6:0] mult_bin;
    logic [14:0] write_en;
    logic       enter_write;

    assign in_scale     = (current_state >= S_SCALE_FIRST) && (current_state <= S_SCALE_LAST);
    assign scale_offset = current_state - 5'd4;
    assign scale_idx    = scale_offset[3:0];
    assign mult_bin     = band_base + {3'd0, state_counter};

    // Band tables: last MULT counter value, first FFT bin and ROM base per scale
    always_comb begin
        band_last = 4'd0;
        band_base = 7'd0;
        rom_base  = 8'd0;
        case (scale_idx)
            4'd1:  begin band_last = 4'd15; band_base = 7'd48; rom_base = 8'd0;   end
            4'd2:  begin band_last = 4'd15; band_base = 7'd40; rom_base = 8'd16;  end
            4'd3:  begin band_last = 4'd15; band_base = 7'd34; rom_base = 8'd32;  end
            4'd4:  begin band_last = 4'd13; band_base = 7'd29; rom_base = 8'd48;  end
            4'd5:  begin band_last = 4'd13; band_base = 7'd25; rom_base = 8'd62;  end
            4'd6:  begin band_last = 4'd13; band_base = 7'd22; rom_base = 8'd76;  end
            4'd7:  begin band_last = 4'd13; band_base = 7'd19; rom_base = 8'd90;  end
            4'd8:  begin band_last = 4'd13; band_base = 7'd17; rom_base = 8'd104; end
            4'd9:  begin band_last = 4'd13; band_base = 7'd15; rom_base = 8'd118; end
            4'd10: begin band_last = 4'd12; band_base = 7'd13; rom_base = 8'd132; end
            4'd11: begin band_last = 4'd12; band_base = 7'd11; rom_base = 8'd145; end
            4'd12: begin band_last = 4'd12; band_base = 7'd10; rom_base = 8'd158; end
            4'd13: begin band_last = 4'd12; band_base = 7'd9;  rom_base = 8'd171; end
            4'd14: begin band_last = 4'd12; band_base = 7'd8;  rom_base = 8'd184; end
            4'd15: begin band_last = 4'd4;  band_base = 7'd7;  rom_base = 8'd197; end
            default: begin band_last = 4'd0; band_base = 7'd0; rom_base = 8'd0;  end
        endcase
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            current_state <= S_IDLE;
            phase         <= P_MULT;
            state_counter <= 4'd0;
            pending       <= 1'b0;
        end else begin
            current_state <= state_next;
            phase         <= phase_next;
            state_counter <= counter_next;
            pending       <= pending_next;
        end
    end

    // Next-state, phase, counter and pending-flag logic
    always_comb begin
        state_next = current_state;
        phase_next = phase;
        case (current_state)
            S_IDLE:        if (fft_ready_inputs) state_next = S_FFT_LOAD;
            S_FFT_LOAD:    if (!fft_ready_inputs) state_next = S_FFT_WAIT;
            S_FFT_WAIT:    if (fft_correct) state_next = S_FFT_CAPTURE;
            S_FFT_CAPTURE: begin
                if (state_counter == 4'd3) begin
                    state_next = S_SCALE_FIRST;
                    phase_next = P_MULT;
                end
            end
            default: begin
                if (in_scale) begin
                    case (phase)
                        P_MULT:  if (state_counter == band_last) phase_next = P_LOAD;
                        // An IFFT result already flagged skips the wait entirely
                        P_LOAD:  if (state_counter == 4'd3)
                                     phase_next = (pending || ifft_correct) ? P_WRITE : P_WAIT;
                        P_WAIT:  if (ifft_correct || pending) phase_next = P_WRITE;
                        default: begin
                            if (state_counter == 4'd3) begin
                                phase_next = P_MULT;
                                state_next = (current_state == S_SCALE_LAST) ? S_IDLE
                                                                             : current_state + 5'd1;
                            end
                        end
                    endcase
                end else begin
                    state_next = S_IDLE;
                    phase_next = P_MULT;
                end
            end
        endcase

        counter_next = ((state_next != current_state) || (phase_next != phase)) ? 4'd0
                                                                                : state_counter + 4'd1;

        enter_write  = in_scale && (phase != P_WRITE) && (phase_next == P_WRITE);
        pending_next = pending;
        if (in_scale && (phase == P_LOAD) && ifft_correct) pending_next = 1'b1;
        if (enter_write) pending_next = 1'b0;
    end

    // Moore output decode of state, phase and counter
    always_comb begin
        reg_en_fft                 = '0;
        sel_mux_128x1              = '0;
        wavlet_rom_addr            = '0;
        reg_en_ifft                = '0;
        ifft_sel_mux_4x1           = '0;
        ifft_ready_inputs          = 1'b0;
        write_en                   = '0;
        ifft_scale_output_ram_addr = '0;
        if (current_state == S_FFT_CAPTURE) begin
            reg_en_fft = {96'd0, 32'hFFFF_FFFF} << {state_counter[1:0], 5'd0};
        end else if (in_scale) begin
            case (phase)
                P_MULT: begin
                    sel_mux_128x1   = mult_bin;
                    wavlet_rom_addr = rom_base + {4'd0, state_counter};
                    reg_en_ifft     = 128'd1 << mult_bin;
                end
                P_LOAD: begin
                    ifft_ready_inputs = 1'b1;
                    ifft_sel_mux_4x1  = state_counter[1:0];
                end
                P_WRITE: begin
                    write_en                   = 15'd1 << (scale_idx - 4'd1);
                    ifft_scale_output_ram_addr = state_counter[1:0];
                end
                default: ;
            endcase
        end
    end

    assign ifft_scale_ram_write_enable_1  = write_en[0];
    assign ifft_scale_ram_write_enable_2  = write_en[1];
    assign ifft_scale_ram_write_enable_3  = write_en[2];
    assign ifft_scale_ram_write_enable_4  = write_en[3];
    assign ifft_scale_ram_write_enable_5  = write_en[4];
    assign ifft_scale_ram_write_enable_6  = write_en[5];
    assign ifft_scale_ram_write_enable_7  = write_en[6];
    assign ifft_scale_ram_write_enable_8  = write_en[7];
    assign ifft_scale_ram_write_enable_9  = write_en[8];
    assign ifft_scale_ram_write_enable_10 = write_en[9];
    assign ifft_scale_ram_write_enable_11 = write_en[10];
    assign ifft_scale_ram_write_enable_12 = write_en[11];
    assign ifft_scale_ram_write_enable_13 = write_en[12];
    assign ifft_scale_ram_write_enable_14 = write_en[13];
    assign ifft_scale_ram_write_enable_15 = write_en[14];

endmodule

// File: tb/tb_controller_fsm_cwt.sv
// Scoreboard bench for controller_fsm_cwt: stimulus pushes expected output
// records tagged with their cycle; a negedge monitor pops one record for every
// cycle on which the DUT drives any output.
module tb_controller_fsm_cwt;

    logic         clk = 1'b0;
    logic         rst;
    logic         fft_ready_inputs, fft_correct, ifft_correct;
    logic [127:0] reg_en_fft, reg_en_ifft;
    logic [6:0]   sel_mux_128x1;
    logic [7:0]   wavlet_rom_addr;
    logic [1:0]   ifft_sel_mux_4x1, ifft_scale_output_ram_addr;
    logic         ifft_ready_inputs;
    logic         we1, we2, we3, we4, we5, we6, we7, we8, we9, we10, we11, we12, we13, we14, we15;

    controller_fsm_cwt dut (
        .clk(clk), .rst(rst),
        .fft_ready_inputs(fft_ready_inputs), .fft_correct(fft_correct), .ifft_correct(ifft_correct),
        .reg_en_fft(reg_en_fft), .sel_mux_128x1(sel_mux_128x1), .wavlet_rom_addr(wavlet_rom_addr),
        .reg_en_ifft(reg_en_ifft), .ifft_sel_mux_4x1(ifft_sel_mux_4x1), .ifft_ready_inputs(ifft_ready_inputs),
        .ifft_scale_ram_write_enable_1(we1),   .ifft_scale_ram_write_enable_2(we2),
        .ifft_scale_ram_write_enable_3(we3),   .ifft_scale_ram_write_enable_4(we4),
        .ifft_scale_ram_write_enable_5(we5),   .ifft_scale_ram_write_enable_6(we6),
        .ifft_scale_ram_write_enable_7(we7),   .ifft_scale_ram_write_enable_8(we8),
        .ifft_scale_ram_write_enable_9(we9),   .ifft_scale_ram_write_enable_10(we10),
        .ifft_scale_ram_write_enable_11(we11), .ifft_scale_ram_write_enable_12(we12),
        .ifft_scale_ram_write_enable_13(we13), .ifft_scale_ram_write_enable_14(we14),
        .ifft_scale_ram_write_enable_15(we15),
        .ifft_scale_output_ram_addr(ifft_scale_output_ram_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [127:0] fft;
        logic [6:0]   sel;
        logic [7:0]   rom;
        logic [127:0] ifft;
        logic [1:0]   mux;
        logic         rdy;
        logic [14:0]  we;
        logic [1:0]   addr;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    // Hand-entered band tables
    int len_t [1:15] = '{16, 16, 16, 14, 14, 14, 14, 14, 14, 13, 13, 13, 13, 13, 5};
    int bin_t [1:15] = '{48, 40, 34, 29, 25, 22, 19, 17, 15, 13, 11, 10, 9, 8, 7};
    int rom_t [1:15] = '{0, 16, 32, 48, 62, 76, 90, 104, 118, 132, 145, 158, 171, 184, 197};

    function automatic exp_t blank(input int c);
        exp_t e;
        e.cyc = c; e.fft = '0; e.sel = '0; e.rom = '0; e.ifft = '0;
        e.mux = '0; e.rdy = 1'b0; e.we = '0; e.addr = '0;
        return e;
    endfunction

    task automatic push_capture(input int f);
        exp_t e;
        logic [127:0] base;
        base = 128'hFFFF_FFFF;
        for (int c = 0; c < 4; c++) begin
            e = blank(f + 1 + c);
            e.fft = base << (32 * c);
            q.push_back(e);
        end
    endtask

    task automatic push_mult(input int s, input int t, input int n);
        exp_t e;
        logic [127:0] one;
        one = 128'd1;
        for (int k = 0; k < n; k++) begin
            e = blank(t + k);
            e.sel  = 7'(bin_t[s] + k);
            e.rom  = 8'(rom_t[s] + k);
            e.ifft = one << (bin_t[s] + k);
            q.push_back(e);
        end
    endtask

    task automatic push_load(input int t);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e = blank(t + k);
            e.rdy = 1'b1;
            e.mux = 2'(k);
            q.push_back(e);
        end
    endtask

    task automatic push_write(input int s, input int w);
        exp_t e;
        logic [14:0] one;
        one = 15'd1;
        for (int a = 0; a < 4; a++) begin
            e = blank(w + a);
            e.we   = one << (s - 1);
            e.addr = 2'(a);
            q.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_ifft;
        ifft_correct = 1'b1;
        @(negedge clk);
        ifft_correct = 1'b0;
    endtask

    task automatic pulse_fft;
        fft_correct = 1'b1;
        @(negedge clk);
        fft_correct = 1'b0;
    endtask

    // Monitor: one scoreboard comparison per cycle with any active output
    always @(negedge clk) begin
        logic [14:0] we_now;
        exp_t e;
        we_now = {we15, we14, we13, we12, we11, we10, we9, we8, we7, we6, we5, we4, we3, we2, we1};
        if (reg_en_fft != 0 || reg_en_ifft != 0 || ifft_ready_inputs || we_now != 0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output cyc=%0d fft=%0h ifft=%0h rdy=%0b we=%0h", cyc,
                         reg_en_fft, reg_en_ifft, ifft_ready_inputs, we_now);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.fft !== reg_en_fft || e.sel !== sel_mux_128x1 ||
                    e.rom !== wavlet_rom_addr || e.ifft !== reg_en_ifft || e.mux !== ifft_sel_mux_4x1 ||
                    e.rdy !== ifft_ready_inputs || e.we !== we_now || e.addr !== ifft_scale_output_ram_addr) begin
                    errors++;
                    $display("FAIL txn: got cyc=%0d fft=%0h sel=%0d rom=%0d ifft=%0h mux=%0d rdy=%0b we=%0h addr=%0d; expected cyc=%0d fft=%0h sel=%0d rom=%0d ifft=%0h mux=%0d rdy=%0b we=%0h addr=%0d",
                             cyc, reg_en_fft, sel_mux_128x1, wavlet_rom_addr, reg_en_ifft, ifft_sel_mux_4x1,
                             ifft_ready_inputs, we_now, ifft_scale_output_ram_addr,
                             e.cyc, e.fft, e.sel, e.rom, e.ifft, e.mux, e.rdy, e.we, e.addr);
                end else begin
                    $display("ok cyc=%0d sel=%0d rom=%0d rdy=%0b mux=%0d we=%0h addr=%0d",
                             cyc, sel_mux_128x1, wavlet_rom_addr, ifft_ready_inputs,
                             ifft_sel_mux_4x1, we_now, ifft_scale_output_ram_addr);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, t, w, p, len;
        rst = 1'b0;
        fft_ready_inputs = 1'b0;
        fft_correct = 1'b0;
        ifft_correct = 1'b0;

        // Reset held: everything zero
        repeat (3) @(negedge clk);
        chk("rst_state", 128'(dut.current_state), 128'd0);
        chk("rst_phase_cnt_pend", 128'({dut.phase, dut.state_counter, dut.pending}), 128'd0);
        chk("rst_reg_en_fft", reg_en_fft, 128'd0);
        chk("rst_reg_en_ifft", reg_en_ifft, 128'd0);
        chk("rst_misc_outputs", 128'({sel_mux_128x1, wavlet_rom_addr, ifft_sel_mux_4x1, ifft_ready_inputs,
                                      we1, we8, we15, ifft_scale_output_ram_addr}), 128'd0);

        // Release: stays idle with quiet inputs
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_after_release", 128'(dut.current_state), 128'd0);

        // FFT input load then wait for the output frame
        fft_ready_inputs = 1'b1;
        repeat (4) @(negedge clk);
        chk("fft_load_state", 128'(dut.current_state), 128'd1);
        fft_ready_inputs = 1'b0;
        repeat (4) @(negedge clk);
        chk("fft_wait_state", 128'(dut.current_state), 128'd2);

        f = cyc;
        push_capture(f);
        push_mult(1, f + 5, 16);
        push_load(f + 21);
        pulse_fft();
        t = f + 5;

        // Walk all 15 scales with a mix of pulse timings
        for (int s = 1; s <= 15; s++) begin
            len = len_t[s];
            if (s == 3) begin
                wait_until(t + 1);      // pulse during MULT must be ignored
                pulse_ifft();
            end
            if (s == 5) begin
                wait_until(t + 2);      // stray FFT pulse must be ignored
                pulse_fft();
            end
            if (s == 2) begin
                p = t + len + 1;        // during LOAD: sets pending
                w = t + len + 4;        // WRITE right after LOAD
            end else begin
                p = t + len + 4 + (s % 3);
                w = p + 1;
            end
            push_write(s, w);
            if (s < 15) begin
                push_mult(s + 1, w + 4, len_t[s + 1]);
                push_load(w + 4 + len_t[s + 1]);
            end
            wait_until(p);
            pulse_ifft();
            if (s == 1) begin
                wait_until(w + 4);
                chk("state_after_scale1", 128'(dut.current_state), 128'd6);
            end
            t = w + 4;
        end
        wait_until(t + 2);
        chk("final_state_idle", 128'(dut.current_state), 128'd0);
        chk("queue_drained_full_run", 128'(q.size()), 128'd0);

        // Reset in the middle of scale 1 MULT aborts the frame
        fft_ready_inputs = 1'b1;
        repeat (2) @(negedge clk);
        fft_ready_inputs = 1'b0;
        repeat (2) @(negedge clk);
        f = cyc;
        push_capture(f);
        push_mult(1, f + 5, 6);
        pulse_fft();
        wait_until(f + 10);
        #1 rst = 1'b0;
        #1;
        chk("abort_reg_en_ifft", reg_en_ifft, 128'd0);
        chk("abort_state", 128'(dut.current_state), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            repeat (3) @(negedge clk);
            pulse_ifft();
        end
        chk("abort_stays_idle", 128'(dut.current_state), 128'd0);
        chk("queue_drained_abort", 128'(q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
